// File: rtl/jk_bank_driver.sv
// Drives a bank of JK cells to a target word, reads Q back and retries on mismatch.
// Optional JK_TOGGLE_EXCITE_EN: differing bits are toggled (J=K=1) instead of set/reset.
module jk_bank_driver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] Q_FB,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RetryW-1:0] MaxRetryW = RetryW'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    t_q;
  logic [RetryW-1:0]   retry_q;
  logic [WIDTH-1:0]    src;
  logic [WIDTH-1:0]    diff;
  logic [WIDTH-1:0]    exc_j;
  logic [WIDTH-1:0]    exc_k;

  // Excitation is taken from the incoming word when idle, else from the held target.
  always_comb begin
    src  = (state_q == StIdle) ? IN_DATA : t_q;
    diff = src ^ Q_FB;
`ifdef JK_TOGGLE_EXCITE_EN
    exc_j = diff;
    exc_k = diff;
`else
    exc_j = src & ~Q_FB;
    exc_k = ~src & Q_FB;
`endif
  end

  assign IN_READY = (state_q == StIdle);
  assign BUSY     = (state_q != StIdle);

  always_ff @(posedge CP) begin
    if (!CD) begin
      state_q <= StIdle;
      t_q     <= '0;
      retry_q <= '0;
      J       <= '0;
      K       <= '0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      J    <= '0;
      K    <= '0;
      DONE <= 1'b0;
      ERR  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (IN_VALID) begin
            t_q     <= IN_DATA;
            retry_q <= '0;
            J       <= exc_j;
            K       <= exc_k;
            state_q <= StDrive;
          end
        end
        StDrive: state_q <= StCheck;
        StCheck: begin
          if (Q_FB == t_q) begin
            DONE    <= 1'b1;
            state_q <= StIdle;
          end else if (retry_q != MaxRetryW) begin
            retry_q <= retry_q + 1'b1;
            J       <= exc_j;
            K       <= exc_k;
            state_q <= StDrive;
          end else begin
            ERR     <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: behavioural JK bank with stuck-at faults plus a
// per-transfer reference that predicts drive count, J/K words and outcome.
module tb_jk_bank_driver;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_RETRY = 3;

  logic             CP = 1'b0;
  logic             CD;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] Q_FB;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] stuck_mask;
  int               stuck_left;
  int               n_vec;
  int               n_err;

  assign Q_FB = bank_q;

  jk_bank_driver #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .CP       (CP),
    .CD       (CD),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .J        (J),
    .K        (K),
    .Q_FB     (Q_FB),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 CP = ~CP;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // JK cell behaviour: Q+ = J&~Q | ~K&Q, with stuck-at-0 bits on faulted drives.
  function automatic logic [WIDTH-1:0] bank_next(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k, input bit stick,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] n;
    n = (j & ~q) | (~k & q);
    if (stick) n = n & ~m;
    return n;
  endfunction

  // One clock: bank takes the J/K presented this cycle, outputs sampled 1 time unit later.
  task automatic tick();
    logic [WIDTH-1:0] nxt;
    bit               stick;
    nxt = bank_q;
    if (!$isunknown(J | K)) begin
      stick = (stuck_left > 0) && ((J | K) != '0);
      nxt   = bank_next(bank_q, J, K, stick, stuck_mask);
      if (stick) stuck_left--;
    end
    @(posedge CP);
    #1;
    bank_q = nxt;
  endtask

  task automatic xfer(input logic [WIDTH-1:0] tgt, input bit keep_valid);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] je [MAX_RETRY+1];
    logic [WIDTH-1:0] ke [MAX_RETRY+1];
    int               sl;
    int               n;
    bit               ok;
    bit               stick;
    q  = bank_q;
    sl = stuck_left;
    ok = 1'b0;
    n  = 0;
    for (int a = 0; a <= int'(MAX_RETRY); a++) begin
`ifdef JK_TOGGLE_EXCITE_EN
      je[a] = tgt ^ q;
      ke[a] = tgt ^ q;
`else
      je[a] = tgt & ~q;
      ke[a] = ~tgt & q;
`endif
      stick = (sl > 0) && ((je[a] | ke[a]) != '0);
      q     = bank_next(q, je[a], ke[a], stick, stuck_mask);
      if (stick) sl--;
      n = a + 1;
      if (q == tgt) begin
        ok = 1'b1;
        break;
      end
    end

    chk1("ready_before_accept", IN_READY, 1'b1);
    IN_VALID = 1'b1;
    IN_DATA  = tgt;
    tick();
    for (int a = 0; a < n; a++) begin
      chk8("drive_j", J, je[a]);
      chk8("drive_k", K, ke[a]);
      chk1("drive_busy", BUSY, 1'b1);
      chk1("drive_ready", IN_READY, 1'b0);
      chk1("drive_done", DONE, 1'b0);
      chk1("drive_err", ERR, 1'b0);
      IN_DATA = 8'($urandom);
      tick();
      chk8("check_j", J, 8'h00);
      chk8("check_k", K, 8'h00);
      chk1("check_busy", BUSY, 1'b1);
      chk1("check_done", DONE, 1'b0);
      chk1("check_err", ERR, 1'b0);
      tick();
    end
    chk1("end_done", DONE, ok);
    chk1("end_err", ERR, !ok);
    chk1("end_busy", BUSY, 1'b0);
    chk1("end_ready", IN_READY, 1'b1);
    chk8("end_j", J, 8'h00);
    chk8("end_k", K, 8'h00);
    if (ok) chk8("bank_reached", bank_q, tgt);
    IN_VALID = keep_valid;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    CD         = 1'b0;
    IN_VALID   = 1'b0;
    IN_DATA    = 8'h00;
    bank_q     = 8'h00;
    stuck_mask = 8'h00;
    stuck_left = 0;
    tick();
    tick();
    chk8("rst_j", J, 8'h00);
    chk8("rst_k", K, 8'h00);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_ready", IN_READY, 1'b1);
    chk1("rst_done", DONE, 1'b0);
    chk1("rst_err", ERR, 1'b0);
    CD = 1'b1;
    IN_DATA = 8'h77;
    tick();
    chk1("idle_ignores_data", BUSY, 1'b0);

    // Set from all-zero, then clear upper nibble from all-ones.
    bank_q = 8'h00;
    xfer(8'hA5, 1'b0);
    bank_q = 8'hFF;
    xfer(8'h0F, 1'b0);

    // Bit 3 stuck permanently: all retries used, then ERR.
    stuck_mask = 8'h08;
    bank_q     = 8'h00;
    stuck_left = 1000;
    xfer(8'h08, 1'b0);
    // Bit 3 stuck for the first drive only: one retry, then DONE.
    stuck_left = 1;
    bank_q     = 8'h00;
    xfer(8'h08, 1'b0);
    stuck_left = 0;

    // Back-to-back with IN_VALID held: second word taken in the DONE cycle.
    bank_q = 8'h00;
    xfer(8'h3C, 1'b1);
    xfer(8'hC3, 1'b0);

    // Reset during CHECK aborts silently; reset also beats IN_VALID.
    bank_q   = 8'h00;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h5A;
    tick();
    IN_VALID = 1'b0;
    tick();
    chk1("in_check_busy", BUSY, 1'b1);
    CD = 1'b0;
    tick();
    chk8("abort_j", J, 8'h00);
    chk8("abort_k", K, 8'h00);
    chk1("abort_busy", BUSY, 1'b0);
    chk1("abort_ready", IN_READY, 1'b1);
    chk1("abort_done", DONE, 1'b0);
    chk1("abort_err", ERR, 1'b0);
    IN_VALID = 1'b1;
    IN_DATA  = 8'h99;
    tick();
    chk1("reset_beats_valid", BUSY, 1'b0);
    CD       = 1'b1;
    IN_VALID = 1'b0;
    tick();
    chk1("post_abort_done", DONE, 1'b0);
    chk1("post_abort_err", ERR, 1'b0);
    // Bank already holds 5A: target equal to Q still runs a full cycle.
    xfer(8'h5A, 1'b0);

    // Random targets, bank states and transient/permanent stuck faults.
    for (int i = 0; i < 40; i++) begin
      bank_q = 8'($urandom);
      if ($urandom_range(3) == 0) begin
        stuck_mask = 8'(1 << $urandom_range(7));
        stuck_left = ($urandom_range(4) == 0) ? 1000 : int'($urandom_range(5));
      end else begin
        stuck_left = 0;
      end
      repeat ($urandom_range(2)) begin
        IN_VALID = 1'b0;
        IN_DATA  = 8'($urandom);
        tick();
        chk1("gap_busy", BUSY, 1'b0);
        chk8("gap_j", J, 8'h00);
      end
      xfer(8'($urandom), 1'b0);
    end
    stuck_left = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
